// File: rtl/ifft_cross_serial_pkg.sv
// Shared types and elaboration-time helpers for the serial inverse butterfly stage.
package ifft_pkg;

   typedef enum logic [1:0] {FILL, PAIR, DRAIN} state_t;

   localparam real PI = 3.14159265358979;

   // Scaled conj(w[k]) component, rounded to nearest: cos for re, +sin for im.
   function automatic int twiddle(input int k, input int n, input int res, input bit im);
      real a;
      real v;
      a = 2.0 * PI * real'(k) / real'(n);
      v = (im ? $sin(a) : $cos(a)) * real'(1 << res);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

endpackage

// File: rtl/ifft_cross_serial_twiddle_mult.sv
// Combinational complex multiply of a half-difference by a twiddle, floored back to BITS.
module ifft_twiddle_mult #(
   parameter int BITS       = 16,
   parameter int RESOLUTION = 4
) (
   input  logic signed [BITS:0]         d_re,
   input  logic signed [BITS:0]         d_im,
   input  logic signed [RESOLUTION+1:0] c_re,
   input  logic signed [RESOLUTION+1:0] c_im,
   output logic signed [BITS-1:0]       p_re,
   output logic signed [BITS-1:0]       p_im
);
   localparam int PW = BITS + RESOLUTION + 4;

   logic signed [PW-1:0] full_re;
   logic signed [PW-1:0] full_im;

   assign full_re = PW'(d_re) * PW'(c_re) - PW'(d_im) * PW'(c_im);
   assign full_im = PW'(d_im) * PW'(c_re) + PW'(d_re) * PW'(c_im);

   // One extra shift folds the /2 of the inverse into the twiddle scaling.
   assign p_re = BITS'(full_re >>> (RESOLUTION + 1));
   assign p_im = BITS'(full_im >>> (RESOLUTION + 1));

endmodule

// File: rtl/ifft_cross_serial.sv
// Streaming inverse radix-2 cross stage: buffers the low half, pairs it with the high half, drains differences.
module ifft_cross_serial
   import ifft_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int BITS       = 16,
   parameter int RESOLUTION = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BITS-1:0] in_re,
   input  logic signed [BITS-1:0] in_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [BITS-1:0] out_re,
   output logic signed [BITS-1:0] out_im,
   output logic                   out_last
);
   localparam int HALF = SIZE / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int TW   = RESOLUTION + 2;
   localparam logic [CW-1:0] LAST_IDX = CW'(HALF - 1);

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic signed [BITS-1:0] mem_re [HALF];
   logic signed [BITS-1:0] mem_im [HALF];
   logic signed [TW-1:0]   rom_re [HALF];
   logic signed [TW-1:0]   rom_im [HALF];

   logic                   ostall, xfer, cnt_last;
   logic signed [BITS:0]   s_re, s_im, d_re, d_im;
   logic signed [BITS-1:0] p_re, p_im;

   for (genvar k = 0; k < HALF; k++) begin : g_rom
      localparam int CR = twiddle(k, SIZE, RESOLUTION, 1'b0);
      localparam int CI = twiddle(k, SIZE, RESOLUTION, 1'b1);
      assign rom_re[k] = TW'(CR);
      assign rom_im[k] = TW'(CI);
   end

   assign ostall   = out_valid && !out_ready;
   assign in_ready = !rst && ((state == FILL) || ((state == PAIR) && !ostall));
   assign xfer     = in_valid && in_ready;
   assign cnt_last = (cnt == LAST_IDX);

   assign s_re = (BITS+1)'(mem_re[cnt]) + (BITS+1)'(in_re);
   assign s_im = (BITS+1)'(mem_im[cnt]) + (BITS+1)'(in_im);
   assign d_re = (BITS+1)'(mem_re[cnt]) - (BITS+1)'(in_re);
   assign d_im = (BITS+1)'(mem_im[cnt]) - (BITS+1)'(in_im);

   ifft_twiddle_mult #(.BITS(BITS), .RESOLUTION(RESOLUTION)) u_mult (
      .d_re (d_re),
      .d_im (d_im),
      .c_re (rom_re[cnt]),
      .c_im (rom_im[cnt]),
      .p_re (p_re),
      .p_im (p_im)
   );

   // The same slot holds X_lo during FILL and the twiddled difference after PAIR.
   always_ff @(posedge clk) begin
      if (xfer) begin
         mem_re[cnt] <= (state == FILL) ? in_re : p_re;
         mem_im[cnt] <= (state == FILL) ? in_im : p_im;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         if (!ostall) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (state)
            FILL: begin
               if (xfer) begin
                  cnt <= cnt_last ? '0 : cnt + CW'(1);
                  if (cnt_last) state <= PAIR;
               end
            end
            PAIR: begin
               if (xfer) begin
                  out_re    <= BITS'(s_re >>> 1);
                  out_im    <= BITS'(s_im >>> 1);
                  out_valid <= 1'b1;
                  cnt       <= cnt_last ? '0 : cnt + CW'(1);
                  if (cnt_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!ostall) begin
                  out_re    <= mem_re[cnt];
                  out_im    <= mem_im[cnt];
                  out_valid <= 1'b1;
                  out_last  <= cnt_last;
                  cnt       <= cnt_last ? '0 : cnt + CW'(1);
                  if (cnt_last) state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
